// File: rtl/alu_pkg.sv
`default_nettype none
// ============================================================================
// Module      : alu_pkg
// Description : Shared opcode/state encodings and helpers for alu_mc.
// Revision    : 1.0 - initial release
// ============================================================================
package alu_pkg;

  typedef enum logic [3:0] {
    OP_ADD  = 4'd0,
    OP_SUB  = 4'd1,
    OP_AND  = 4'd2,
    OP_OR   = 4'd3,
    OP_XOR  = 4'd4,
    OP_NOT  = 4'd5,
    OP_SHL  = 4'd6,
    OP_SHR  = 4'd7,
    OP_INC  = 4'd8,
    OP_DEC  = 4'd9,
    OP_ADC  = 4'd10,
    OP_SBB  = 4'd11,
    OP_MUL  = 4'd12,
    OP_MULH = 4'd13,
    OP_DIV  = 4'd14,
    OP_MOD  = 4'd15
  } op_e;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_BUSY = 2'd1,
    ST_DONE = 2'd2
  } state_e;

  // Opcodes served by the iterative multiplier/divider
  function automatic logic is_iterative(input op_e op);
    return (op == OP_MUL) || (op == OP_MULH) || (op == OP_DIV) || (op == OP_MOD);
  endfunction

  // Opcodes that use the divider (and therefore can divide by zero)
  function automatic logic is_divide(input op_e op);
    return (op == OP_DIV) || (op == OP_MOD);
  endfunction

endpackage
`default_nettype wire

// File: rtl/alu_seq_muldiv.sv
`default_nettype none
// ============================================================================
// Module      : alu_seq_muldiv
// Description : Iterative unsigned multiplier (shift-add) and restoring
//               divider, one bit per cycle. The hi/lo outputs present the
//               register values after the current iteration, so the result
//               is available on the cycle done_o is high.
//               MUL: {hi,lo} = product.  DIV: lo = quotient, hi = remainder.
// Revision    : 1.0 - initial release
// ============================================================================
module alu_seq_muldiv #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start_i,
  input  logic             div_i,
  input  logic [WIDTH-1:0] a_i,
  input  logic [WIDTH-1:0] b_i,
  output logic             done_o,
  output logic [WIDTH-1:0] hi_o,
  output logic [WIDTH-1:0] lo_o
);

  localparam int CNT_W = $clog2(WIDTH) + 1;

  logic [CNT_W-1:0] cnt_q;
  logic             run_q;
  logic             div_q;
  logic [WIDTH-1:0] hi_q, hi_d;
  logic [WIDTH-1:0] lo_q, lo_d;
  logic [WIDTH-1:0] opd_q;
  logic [WIDTH:0]   sum;
  logic [WIDTH:0]   shifted;
  logic [WIDTH:0]   trial;

  // One iteration step: shift-add for multiply, restoring step for divide
  always_comb begin
    hi_d    = hi_q;
    lo_d    = lo_q;
    sum     = '0;
    shifted = '0;
    trial   = '0;
    if (div_q) begin
      // Remainder shifts left taking the next dividend bit; a non-negative
      // trial subtraction keeps the difference and sets the quotient bit.
      shifted = {hi_q, lo_q[WIDTH-1]};
      trial   = shifted - {1'b0, opd_q};
      if (!trial[WIDTH]) begin
        hi_d = trial[WIDTH-1:0];
        lo_d = {lo_q[WIDTH-2:0], 1'b1};
      end else begin
        hi_d = shifted[WIDTH-1:0];
        lo_d = {lo_q[WIDTH-2:0], 1'b0};
      end
    end else begin
      // Add multiplicand when multiplier LSB is set, then shift {hi,lo} right
      sum  = {1'b0, hi_q} + (lo_q[0] ? {1'b0, opd_q} : '0);
      hi_d = sum[WIDTH:1];
      lo_d = {sum[0], lo_q[WIDTH-1:1]};
    end
  end

  assign done_o = run_q && (cnt_q == CNT_W'(1));
  assign hi_o   = hi_d;
  assign lo_o   = lo_d;

  // Operand load on start, then WIDTH iterations with a down-counter
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= '0;
      run_q <= 1'b0;
      div_q <= 1'b0;
      hi_q  <= '0;
      lo_q  <= '0;
      opd_q <= '0;
    end else if (start_i) begin
      cnt_q <= CNT_W'(WIDTH);
      run_q <= 1'b1;
      div_q <= div_i;
      hi_q  <= '0;
      lo_q  <= a_i;
      opd_q <= b_i;
    end else if (run_q) begin
      cnt_q <= cnt_q - CNT_W'(1);
      hi_q  <= hi_d;
      lo_q  <= lo_d;
      if (cnt_q == CNT_W'(1)) begin
        run_q <= 1'b0;
      end
    end
  end

endmodule
`default_nettype wire

// File: rtl/alu_mc.sv
`default_nettype none
// ============================================================================
// Module      : alu_mc
// Description : Parametrised multi-cycle ALU with valid/ready handshakes,
//               persistent carry/borrow for ADC/SBB, and an iterative
//               multiplier/divider for MUL/MULH/DIV/MOD.
// Revision    : 1.0 - initial release
// ============================================================================
module alu_mc
  import alu_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic [3:0]       opcode,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] y,
  output logic             cout,
  output logic             bout,
  output logic             zero,
  output logic             neg,
  output logic             dz,
  output logic             busy
);

  op_e              op_in;
  op_e              op_q;
  state_e           state_q;
  logic             in_ready_q, out_valid_q, busy_q;
  logic [WIDTH-1:0] y_q;
  logic             cout_q, bout_q, zero_q, neg_q, dz_q;
  logic             carry_q, borrow_q;

  logic [WIDTH:0]   sum_ab, dif_ab, adc_ab, sbb_ab, inc_a, dec_a;
  logic [WIDTH-1:0] res_d;
  logic             cout_d, bout_d, dz_d;
  logic             accept, go_busy;

  logic             md_done;
  logic [WIDTH-1:0] md_hi, md_lo, md_y;

  assign op_in   = op_e'(opcode);
  assign accept  = in_valid && in_ready_q;
  // MUL/MULH always iterate; DIV/MOD only when the divisor is non-zero
  assign go_busy = is_iterative(op_in) && !(is_divide(op_in) && (b == '0));

  assign sum_ab = {1'b0, a} + {1'b0, b};
  assign dif_ab = {1'b0, a} - {1'b0, b};
  assign adc_ab = sum_ab + {{WIDTH{1'b0}}, carry_q};
  assign sbb_ab = dif_ab - {{WIDTH{1'b0}}, borrow_q};
  assign inc_a  = {1'b0, a} + (WIDTH+1)'(1);
  assign dec_a  = {1'b0, a} - (WIDTH+1)'(1);

  // Single-cycle result and flags; bit WIDTH is carry or (negative) borrow
  always_comb begin
    res_d  = '0;
    cout_d = 1'b0;
    bout_d = 1'b0;
    dz_d   = 1'b0;
    case (op_in)
      OP_ADD: {cout_d, res_d} = sum_ab;
      OP_SUB: {bout_d, res_d} = dif_ab;
      OP_AND: res_d = a & b;
      OP_OR:  res_d = a | b;
      OP_XOR: res_d = a ^ b;
      OP_NOT: res_d = ~a;
      OP_SHL: begin
        res_d  = {a[WIDTH-2:0], 1'b0};
        cout_d = a[WIDTH-1];
      end
      OP_SHR: begin
        res_d  = {1'b0, a[WIDTH-1:1]};
        cout_d = a[0];
      end
      OP_INC: {cout_d, res_d} = inc_a;
      OP_DEC: {bout_d, res_d} = dec_a;
      OP_ADC: {cout_d, res_d} = adc_ab;
      OP_SBB: {bout_d, res_d} = sbb_ab;
      OP_DIV: begin
        if (b == '0) begin
          res_d = '1;
          dz_d  = 1'b1;
        end
      end
      OP_MOD: begin
        if (b == '0) begin
          res_d = a;
          dz_d  = 1'b1;
        end
      end
      default: res_d = '0;
    endcase
  end

  // Pick the iterative result half that the captured opcode asked for
  always_comb begin
    case (op_q)
      OP_MULH, OP_MOD: md_y = md_hi;
      default:         md_y = md_lo;
    endcase
  end

  alu_seq_muldiv #(
    .WIDTH (WIDTH)
  ) u_muldiv (
    .clk     (clk),
    .rst_n   (rst_n),
    .start_i (accept && go_busy),
    .div_i   (is_divide(op_in)),
    .a_i     (a),
    .b_i     (b),
    .done_o  (md_done),
    .hi_o    (md_hi),
    .lo_o    (md_lo)
  );

  // Handshake FSM with registered result, flags and stored carry/borrow
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= ST_IDLE;
      op_q        <= OP_ADD;
      in_ready_q  <= 1'b1;
      out_valid_q <= 1'b0;
      busy_q      <= 1'b0;
      y_q         <= '0;
      cout_q      <= 1'b0;
      bout_q      <= 1'b0;
      zero_q      <= 1'b0;
      neg_q       <= 1'b0;
      dz_q        <= 1'b0;
      carry_q     <= 1'b0;
      borrow_q    <= 1'b0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (accept) begin
            op_q       <= op_in;
            in_ready_q <= 1'b0;
            if (go_busy) begin
              state_q <= ST_BUSY;
              busy_q  <= 1'b1;
            end else begin
              state_q     <= ST_DONE;
              out_valid_q <= 1'b1;
              y_q         <= res_d;
              cout_q      <= cout_d;
              bout_q      <= bout_d;
              dz_q        <= dz_d;
              zero_q      <= (res_d == '0);
              neg_q       <= res_d[WIDTH-1];
              if (op_in == OP_ADD || op_in == OP_ADC || op_in == OP_INC) begin
                carry_q <= cout_d;
              end
              if (op_in == OP_SUB || op_in == OP_SBB || op_in == OP_DEC) begin
                borrow_q <= bout_d;
              end
            end
          end
        end
        ST_BUSY: begin
          if (md_done) begin
            state_q     <= ST_DONE;
            busy_q      <= 1'b0;
            out_valid_q <= 1'b1;
            y_q         <= md_y;
            cout_q      <= 1'b0;
            bout_q      <= 1'b0;
            dz_q        <= 1'b0;
            zero_q      <= (md_y == '0);
            neg_q       <= md_y[WIDTH-1];
          end
        end
        ST_DONE: begin
          if (out_ready) begin
            state_q     <= ST_IDLE;
            out_valid_q <= 1'b0;
            in_ready_q  <= 1'b1;
          end
        end
        default: begin
          state_q     <= ST_IDLE;
          in_ready_q  <= 1'b1;
          out_valid_q <= 1'b0;
          busy_q      <= 1'b0;
        end
      endcase
    end
  end

  assign in_ready  = in_ready_q;
  assign out_valid = out_valid_q;
  assign busy      = busy_q;
  assign y         = y_q;
  assign cout      = cout_q;
  assign bout      = bout_q;
  assign zero      = zero_q;
  assign neg       = neg_q;
  assign dz        = dz_q;

endmodule
`default_nettype wire

// File: tb/tb_alu_mc.sv
`default_nettype none
// ============================================================================
// Module      : tb_alu_mc
// Description : Self-checking bench for alu_mc at WIDTH=8 and WIDTH=16.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_alu_mc;

  typedef struct packed {
    logic        w16;
    logic [3:0]  op;
    logic [15:0] a;
    logic [15:0] b;
    logic [15:0] y;
    logic        cout;
    logic        bout;
    logic        dz;
    logic [7:0]  lat;
  } vec_t;

  typedef struct packed {
    logic [15:0] y;
    logic        cout;
    logic        bout;
    logic        dz;
  } exp_t;

  logic clk = 1'b0;
  logic rst_n = 1'b0;

  logic       in_valid8 = 1'b0, in_ready8, out_valid8, out_ready8 = 1'b1;
  logic [7:0] a8 = '0, b8 = '0, y8;
  logic [3:0] opcode8 = '0;
  logic       cout8, bout8, zero8, neg8, dz8, busy8;

  logic        in_valid16 = 1'b0, in_ready16, out_valid16, out_ready16 = 1'b1;
  logic [15:0] a16 = '0, b16 = '0, y16;
  logic [3:0]  opcode16 = '0;
  logic        cout16, bout16, zero16, neg16, dz16, busy16;

  int   n_checks = 0;
  int   n_fail = 0;
  exp_t q8[$];
  exp_t q16[$];
  exp_t e8, e16;
  vec_t tbl[$];

  logic sel16 = 1'b0;
  logic ov, bz, ir;
  assign ov = sel16 ? out_valid16 : out_valid8;
  assign bz = sel16 ? busy16 : busy8;
  assign ir = sel16 ? in_ready16 : in_ready8;

  always #5 clk = ~clk;

  alu_mc #(.WIDTH(8)) dut8 (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid8), .in_ready(in_ready8),
    .a(a8), .b(b8), .opcode(opcode8), .out_valid(out_valid8),
    .out_ready(out_ready8), .y(y8), .cout(cout8), .bout(bout8),
    .zero(zero8), .neg(neg8), .dz(dz8), .busy(busy8)
  );

  alu_mc #(.WIDTH(16)) dut16 (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid16), .in_ready(in_ready16),
    .a(a16), .b(b16), .opcode(opcode16), .out_valid(out_valid16),
    .out_ready(out_ready16), .y(y16), .cout(cout16), .bout(bout16),
    .zero(zero16), .neg(neg16), .dz(dz16), .busy(busy16)
  );

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", nm, act, exp);
    end
  endtask

  function automatic vec_t mk(input logic w16, input logic [3:0] op,
                              input logic [15:0] a, input logic [15:0] b,
                              input logic [15:0] y, input logic c,
                              input logic bo, input logic dzv, input logic [7:0] lat);
    vec_t v;
    v.w16 = w16; v.op = op; v.a = a; v.b = b; v.y = y;
    v.cout = c; v.bout = bo; v.dz = dzv; v.lat = lat;
    return v;
  endfunction

  // Scoreboard: compare each handshaken WIDTH=8 result with the oldest expectation
  always @(negedge clk) begin
    if (out_valid8 && out_ready8) begin
      if (q8.size() == 0) begin
        n_checks++;
        n_fail++;
        $display("FAIL unexpected_result8: got y=0x%0h expected no result", y8);
      end else begin
        e8 = q8.pop_front();
        chk("y8", 32'(y8), 32'(e8.y[7:0]));
        chk("cout8", 32'(cout8), 32'(e8.cout));
        chk("bout8", 32'(bout8), 32'(e8.bout));
        chk("dz8", 32'(dz8), 32'(e8.dz));
        chk("zero8", 32'(zero8), 32'(e8.y[7:0] == 8'h00));
        chk("neg8", 32'(neg8), 32'(e8.y[7]));
      end
    end
  end

  // Scoreboard for the WIDTH=16 instance
  always @(negedge clk) begin
    if (out_valid16 && out_ready16) begin
      if (q16.size() == 0) begin
        n_checks++;
        n_fail++;
        $display("FAIL unexpected_result16: got y=0x%0h expected no result", y16);
      end else begin
        e16 = q16.pop_front();
        chk("y16", 32'(y16), 32'(e16.y));
        chk("cout16", 32'(cout16), 32'(e16.cout));
        chk("bout16", 32'(bout16), 32'(e16.bout));
        chk("dz16", 32'(dz16), 32'(e16.dz));
        chk("zero16", 32'(zero16), 32'(e16.y == 16'h0000));
        chk("neg16", 32'(neg16), 32'(e16.y[15]));
      end
    end
  end

  // Drive one operation, measure latency/busy/in_ready, wait for return to IDLE
  task automatic run(input vec_t v);
    int lat, nbusy, nready;
    exp_t e;
    e.y = v.y; e.cout = v.cout; e.bout = v.bout; e.dz = v.dz;
    sel16 = v.w16;
    @(negedge clk);
    if (v.w16) begin
      a16 = v.a; b16 = v.b; opcode16 = v.op; in_valid16 = 1'b1;
      q16.push_back(e);
    end else begin
      a8 = v.a[7:0]; b8 = v.b[7:0]; opcode8 = v.op; in_valid8 = 1'b1;
      q8.push_back(e);
    end
    @(posedge clk); #1;
    in_valid8 = 1'b0;
    in_valid16 = 1'b0;
    lat = 1; nbusy = 0; nready = 0;
    while (!ov && lat < 64) begin
      if (bz) nbusy++;
      if (ir) nready++;
      @(posedge clk); #1;
      lat++;
    end
    chk("latency", 32'(lat), 32'(v.lat));
    chk("busy_cycles", 32'(nbusy), 32'(v.lat) - 32'd1);
    chk("in_ready_while_pending", 32'(nready), 32'd0);
    @(posedge clk); #1;
    chk("back_to_idle", 32'({ir, ov}), 32'b10);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, expected completion");
    $fatal(1);
  end

  initial begin
    // WIDTH=8 single-cycle ops
    tbl.push_back(mk(0, 4'd0,  16'h3C, 16'h12, 16'h4E, 0, 0, 0, 1));
    tbl.push_back(mk(0, 4'd1,  16'h3C, 16'h12, 16'h2A, 0, 0, 0, 1));
    tbl.push_back(mk(0, 4'd2,  16'h3C, 16'h12, 16'h10, 0, 0, 0, 1));
    tbl.push_back(mk(0, 4'd3,  16'h3C, 16'h12, 16'h3E, 0, 0, 0, 1));
    tbl.push_back(mk(0, 4'd4,  16'h3C, 16'h12, 16'h2E, 0, 0, 0, 1));
    tbl.push_back(mk(0, 4'd5,  16'h3C, 16'h12, 16'hC3, 0, 0, 0, 1));
    tbl.push_back(mk(0, 4'd6,  16'h3C, 16'h12, 16'h78, 0, 0, 0, 1));
    tbl.push_back(mk(0, 4'd7,  16'h3C, 16'h12, 16'h1E, 0, 0, 0, 1));
    tbl.push_back(mk(0, 4'd8,  16'h3C, 16'h12, 16'h3D, 0, 0, 0, 1));
    tbl.push_back(mk(0, 4'd9,  16'h3C, 16'h12, 16'h3B, 0, 0, 0, 1));
    tbl.push_back(mk(0, 4'd10, 16'h3C, 16'h12, 16'h4E, 0, 0, 0, 1));
    tbl.push_back(mk(0, 4'd11, 16'h3C, 16'h12, 16'h2A, 0, 0, 0, 1));
    // Carry/borrow chain
    tbl.push_back(mk(0, 4'd0,  16'hFF, 16'h01, 16'h00, 1, 0, 0, 1));
    tbl.push_back(mk(0, 4'd10, 16'h00, 16'h00, 16'h01, 0, 0, 0, 1));
    tbl.push_back(mk(0, 4'd1,  16'h12, 16'h3C, 16'hD6, 0, 1, 0, 1));
    tbl.push_back(mk(0, 4'd11, 16'h05, 16'h01, 16'h03, 0, 0, 0, 1));
    // Boundary flags; C/B survive the unrelated ops in between
    tbl.push_back(mk(0, 4'd8,  16'hFF, 16'h00, 16'h00, 1, 0, 0, 1));
    tbl.push_back(mk(0, 4'd9,  16'h00, 16'h00, 16'hFF, 0, 1, 0, 1));
    tbl.push_back(mk(0, 4'd6,  16'h81, 16'h00, 16'h02, 1, 0, 0, 1));
    tbl.push_back(mk(0, 4'd7,  16'h81, 16'h00, 16'h40, 1, 0, 0, 1));
    tbl.push_back(mk(0, 4'd2,  16'hFF, 16'h0F, 16'h0F, 0, 0, 0, 1));
    tbl.push_back(mk(0, 4'd10, 16'h10, 16'h20, 16'h31, 0, 0, 0, 1));
    tbl.push_back(mk(0, 4'd11, 16'h10, 16'h01, 16'h0E, 0, 0, 0, 1));
    // Iterative ops
    tbl.push_back(mk(0, 4'd12, 16'h3C, 16'h12, 16'h38, 0, 0, 0, 9));
    tbl.push_back(mk(0, 4'd13, 16'h3C, 16'h12, 16'h04, 0, 0, 0, 9));
    tbl.push_back(mk(0, 4'd14, 16'h3C, 16'h12, 16'h03, 0, 0, 0, 9));
    tbl.push_back(mk(0, 4'd15, 16'h3C, 16'h12, 16'h06, 0, 0, 0, 9));
    tbl.push_back(mk(0, 4'd12, 16'h3C, 16'h00, 16'h00, 0, 0, 0, 9));
    tbl.push_back(mk(0, 4'd13, 16'hFF, 16'hFF, 16'hFE, 0, 0, 0, 9));
    tbl.push_back(mk(0, 4'd14, 16'hFF, 16'h01, 16'hFF, 0, 0, 0, 9));
    tbl.push_back(mk(0, 4'd15, 16'h05, 16'h07, 16'h05, 0, 0, 0, 9));
    // Divide by zero
    tbl.push_back(mk(0, 4'd14, 16'h3C, 16'h00, 16'hFF, 0, 0, 1, 1));
    tbl.push_back(mk(0, 4'd15, 16'h3C, 16'h00, 16'h3C, 0, 0, 1, 1));
    // WIDTH=16
    tbl.push_back(mk(1, 4'd12, 16'h1234, 16'h0010, 16'h2340, 0, 0, 0, 17));
    tbl.push_back(mk(1, 4'd13, 16'h1234, 16'h0010, 16'h0001, 0, 0, 0, 17));
    tbl.push_back(mk(1, 4'd14, 16'h1234, 16'h0010, 16'h0123, 0, 0, 0, 17));
    tbl.push_back(mk(1, 4'd15, 16'h1234, 16'h0010, 16'h0004, 0, 0, 0, 17));
    tbl.push_back(mk(1, 4'd0,  16'hFFFF, 16'h0001, 16'h0000, 1, 0, 0, 1));
    tbl.push_back(mk(1, 4'd10, 16'h0000, 16'h0000, 16'h0001, 0, 0, 0, 1));
    tbl.push_back(mk(1, 4'd14, 16'h1234, 16'h0000, 16'hFFFF, 0, 0, 1, 1));

    // Reset state
    repeat (2) @(posedge clk);
    #1;
    chk("rst_in_ready", 32'(in_ready8), 32'd1);
    chk("rst_out_valid", 32'(out_valid8), 32'd0);
    chk("rst_busy", 32'(busy8), 32'd0);
    chk("rst_y", 32'(y8), 32'd0);
    chk("rst_flags", 32'({cout8, bout8, zero8, neg8, dz8}), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;

    for (int i = 0; i < tbl.size(); i++) begin
      run(tbl[i]);
    end

    // Backpressure: result held, new in_valid ignored while in DONE
    sel16 = 1'b0;
    out_ready8 = 1'b0;
    @(negedge clk);
    a8 = 8'h01; b8 = 8'h02; opcode8 = 4'd0; in_valid8 = 1'b1;
    q8.push_back('{y: 16'h0003, cout: 1'b0, bout: 1'b0, dz: 1'b0});
    @(posedge clk); #1;
    in_valid8 = 1'b0;
    chk("bp_valid_first", 32'(out_valid8), 32'd1);
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      a8 = 8'h10; b8 = 8'h10; opcode8 = 4'd0; in_valid8 = 1'b1;
      @(posedge clk); #1;
      chk("bp_valid_held", 32'(out_valid8), 32'd1);
      chk("bp_y_held", 32'(y8), 32'h03);
      chk("bp_in_ready", 32'(in_ready8), 32'd0);
    end
    in_valid8 = 1'b0;
    out_ready8 = 1'b1;
    @(posedge clk); #1;
    chk("bp_release", 32'({in_ready8, out_valid8}), 32'b10);
    chk("bp_y_after", 32'(y8), 32'h03);
    run(mk(0, 4'd0, 16'h10, 16'h10, 16'h20, 0, 0, 0, 1));

    // Reset mid-MUL with C=B=1 beforehand
    run(mk(0, 4'd8, 16'hFF, 16'h00, 16'h00, 1, 0, 0, 1));
    run(mk(0, 4'd9, 16'h00, 16'h00, 16'hFF, 0, 1, 0, 1));
    @(negedge clk);
    a8 = 8'h3C; b8 = 8'h12; opcode8 = 4'd12; in_valid8 = 1'b1;
    @(posedge clk); #1;
    in_valid8 = 1'b0;
    repeat (3) @(posedge clk);
    #2;
    chk("pre_rst_busy", 32'(busy8), 32'd1);
    rst_n = 1'b0;
    #1;
    chk("async_rst_out_valid", 32'(out_valid8), 32'd0);
    chk("async_rst_in_ready", 32'(in_ready8), 32'd1);
    chk("async_rst_busy", 32'(busy8), 32'd0);
    chk("async_rst_y", 32'(y8), 32'd0);
    chk("async_rst_flags", 32'({cout8, bout8, zero8, neg8, dz8}), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    run(mk(0, 4'd10, 16'h00, 16'h00, 16'h00, 0, 0, 0, 1));
    run(mk(0, 4'd11, 16'h05, 16'h01, 16'h04, 0, 0, 0, 1));
    run(mk(0, 4'd0,  16'h01, 16'h01, 16'h02, 0, 0, 0, 1));

    repeat (3) @(posedge clk);
    #1;
    chk("q8_drained", 32'(q8.size()), 32'd0);
    chk("q16_drained", 32'(q16.size()), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
